// File: rtl/bram_burst_arbiter.sv
// bram_burst_arbiter
// Two-requester, burst-granular round-robin arbiter in front of a
// single-port BRAM with one cycle of read latency. The granted requester
// owns the memory for its whole burst. Burst addresses wrap modulo MEM_SIZE.
module bram_burst_arbiter #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int MEM_SIZE = 3840
) (
  input  logic              clk,
  input  logic              reset_n,
  // requester 0
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [AWIDTH-1:0] i_addr0,
  input  logic [AWIDTH-1:0] i_len0,
  input  logic [DWIDTH-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_done0,
  output logic              o_rvalid0,
  output logic [DWIDTH-1:0] o_rdata0,
  // requester 1
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [AWIDTH-1:0] i_addr1,
  input  logic [AWIDTH-1:0] i_len1,
  input  logic [DWIDTH-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_done1,
  output logic              o_rvalid1,
  output logic [DWIDTH-1:0] o_rdata1,
  // status
  output logic              o_idle,
  // BRAM port
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] q0
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST0 = 2'd1,
    S_BURST1 = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last legal address; the wrap point for the running burst address.
  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(MEM_SIZE - 1);
  // Compared one bit wider so a MEM_SIZE of exactly 2^AWIDTH still works.
  localparam logic [AWIDTH:0]   SIZE_EXT  = (AWIDTH + 1)'(MEM_SIZE);

  state_t              state_q, state_d;
  logic                last_q, last_d;     // requester served most recently
  logic                owner_q, owner_d;   // requester of the current/just-finished burst
  logic                we_q, we_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [AWIDTH-1:0]   len_q, len_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;

  // Winner of the current idle-cycle arbitration and its latched request.
  logic                pick;
  logic [AWIDTH-1:0]   pick_addr;
  logic [AWIDTH:0]     pick_addr_ext;
  logic [AWIDTH-1:0]   pick_addr_red;
  logic                in_burst;
  logic                beat;

  // Arbitration: a single request wins outright; a tie goes to the requester
  // that was not served last. Start addresses at or beyond MEM_SIZE are folded
  // back once here so the burst logic only ever sees in-range addresses.
  always_comb begin
    pick          = 1'b0;
    pick_addr     = '0;
    pick_addr_ext = '0;
    pick_addr_red = '0;
    if (i_req0 && i_req1) begin
      pick = ~last_q;
    end else begin
      pick = i_req1;
    end
    pick_addr     = pick ? i_addr1 : i_addr0;
    pick_addr_ext = {1'b0, pick_addr};
    if (pick_addr_ext >= SIZE_EXT) begin
      pick_addr_red = pick_addr - AWIDTH'(MEM_SIZE);
    end else begin
      pick_addr_red = pick_addr;
    end
  end

  // A beat is issued in every burst-state cycle unless the burst is empty.
  always_comb begin
    in_burst = (state_q == S_BURST0) || (state_q == S_BURST1);
    beat     = in_burst && (len_q != '0);
  end

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          owner_d = pick;
          last_d  = pick;
          we_d    = pick ? i_we1  : i_we0;
          len_d   = pick ? i_len1 : i_len0;
          addr_d  = pick_addr_red;
          cnt_d   = '0;
          state_d = pick ? S_BURST1 : S_BURST0;
        end
      end

      S_BURST0, S_BURST1: begin
        // An empty burst still spends one cycle here (no beat) so that its
        // done pulse lands two cycles after the sampling cycle.
        if (len_q == '0) begin
          state_d = S_DONE;
        end else begin
          rvalid0_d = (state_q == S_BURST0) && !we_q;
          rvalid1_d = (state_q == S_BURST1) && !we_q;
          cnt_d     = cnt_q + AWIDTH'(1);
          addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + AWIDTH'(1);
          if (cnt_q == len_q - AWIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and burst registers; reset leaves requester 0 as first tie winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Requester-side outputs, all decoded from registered state.
  always_comb begin
    o_gnt0    = beat && (state_q == S_BURST0);
    o_gnt1    = beat && (state_q == S_BURST1);
    o_done0   = (state_q == S_DONE) && !owner_q;
    o_done1   = (state_q == S_DONE) &&  owner_q;
    o_rvalid0 = rvalid0_q;
    o_rvalid1 = rvalid1_q;
    o_rdata0  = rvalid0_q ? q0 : '0;
    o_rdata1  = rvalid1_q ? q0 : '0;
    o_idle    = (state_q == S_IDLE);
  end

  // BRAM port: quiet outside beats; write data taken live from the owner.
  always_comb begin
    ce0   = beat;
    we0   = beat && we_q;
    addr0 = beat ? addr_q : '0;
    d0    = '0;
    if (beat && we_q) begin
      d0 = (state_q == S_BURST1) ? i_wdata1 : i_wdata0;
    end
  end

endmodule

// File: tb/tb_bram_burst_arbiter.sv
// tb_bram_burst_arbiter
// Directed, table-driven bench for bram_burst_arbiter with a behavioural
// single-port BRAM (1-cycle read latency) attached to the memory port.
module tb_bram_burst_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int MS = 3840;

  logic          clk;
  logic          reset_n;
  logic          i_req0, i_req1, i_we0, i_we1;
  logic [AW-1:0] i_addr0, i_addr1, i_len0, i_len1;
  logic [DW-1:0] i_wdata0, i_wdata1;
  logic          o_gnt0, o_gnt1, o_done0, o_done1, o_rvalid0, o_rvalid1, o_idle;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic [AW-1:0] addr0;
  logic          ce0, we0;
  logic [DW-1:0] d0, q0;

  int checks = 0;
  int errors = 0;

  bram_burst_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_len0(i_len0), .i_wdata0(i_wdata0),
    .o_gnt0(o_gnt0), .o_done0(o_done0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_len1(i_len1), .i_wdata1(i_wdata1),
    .o_gnt1(o_gnt1), .o_done1(o_done1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
    .o_idle(o_idle), .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural BRAM.
  logic [DW-1:0] mem [0:MS-1];
  initial begin
    for (int i = 0; i < MS; i++) mem[i] = '0;
    q0 = '0;
  end
  always @(posedge clk) begin
    if (ce0) begin
      if (we0) mem[addr0] <= d0;
      else     q0 <= mem[addr0];
    end
  end

  // Per-cycle vector: inputs (shared by both requesters except req) and
  // expected outputs. g/dn/rv are {requester1, requester0}.
  typedef struct {
    logic          r0, r1, wr;
    logic [AW-1:0] a, l;
    logic [DW-1:0] wd;
    logic [1:0]    g, dn, rv;
    logic          idle, ce, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r0, input logic r1, input logic wr,
                              input int a, input int l, input int wd,
                              input int g, input int dn, input int rv,
                              input logic idle, input logic ce, input logic we,
                              input int ad, input int d, input int rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.wr = wr;
    v.a = a[AW-1:0]; v.l = l[AW-1:0]; v.wd = wd[DW-1:0];
    v.g = g[1:0]; v.dn = dn[1:0]; v.rv = rv[1:0];
    v.idle = idle; v.ce = ce; v.we = we;
    v.ad = ad[AW-1:0]; v.d = d[DW-1:0]; v.rd = rd[DW-1:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [52:0]   act, expv;
  logic [DW-1:0] rsel;

  initial begin
    reset_n = 1'b0;
    i_req0 = 0; i_req1 = 0; i_we0 = 0; i_we1 = 0;
    i_addr0 = '0; i_addr1 = '0; i_len0 = '0; i_len1 = '0;
    i_wdata0 = '0; i_wdata1 = '0;

    //                 r0 r1 wr  a     l  wd    g dn rv idle ce we  ad    d    rd
    // write burst, requester 0, addr 0, len 4 (addr/len changed mid-burst)
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(1, 0, 1, 0,    4, 100,  0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 1, 7,    9, 100,  1, 0, 0, 0, 1, 1, 0,    100, 0));
    tbl.push_back(mk(0, 0, 1, 7,    9, 101,  1, 0, 0, 0, 1, 1, 1,    101, 0));
    tbl.push_back(mk(0, 0, 1, 7,    9, 102,  1, 0, 0, 0, 1, 1, 2,    102, 0));
    tbl.push_back(mk(0, 0, 1, 7,    9, 103,  1, 0, 0, 0, 1, 1, 3,    103, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 1, 0, 0, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    // read burst, requester 1, addr 0, len 4
    tbl.push_back(mk(0, 1, 0, 0,    4, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    2, 0, 0, 0, 1, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    2, 0, 2, 0, 1, 0, 1,    0,   100));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    2, 0, 2, 0, 1, 0, 2,    0,   101));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    2, 0, 2, 0, 1, 0, 3,    0,   102));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 2, 2, 0, 0, 0, 0,    0,   103));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    // both requesters held, read len 2: 0,1,0,1
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    1, 0, 0, 0, 1, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    1, 0, 1, 0, 1, 0, 1,    0,   100));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 1, 1, 0, 0, 0, 0,    0,   101));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    2, 0, 0, 0, 1, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    2, 0, 2, 0, 1, 0, 1,    0,   100));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 2, 2, 0, 0, 0, 0,    0,   101));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    1, 0, 0, 0, 1, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    1, 0, 1, 0, 1, 0, 1,    0,   100));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 1, 1, 0, 0, 0, 0,    0,   101));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    2, 0, 0, 0, 1, 0, 0,    0,   0));
    tbl.push_back(mk(1, 1, 0, 0,    2, 0,    2, 0, 2, 0, 1, 0, 1,    0,   100));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 2, 2, 0, 0, 0, 0,    0,   101));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    // address wrap: write addr 3838, len 4
    tbl.push_back(mk(1, 0, 1, 3838, 4, 200,  0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 1, 0,    0, 200,  1, 0, 0, 0, 1, 1, 3838, 200, 0));
    tbl.push_back(mk(0, 0, 1, 0,    0, 201,  1, 0, 0, 0, 1, 1, 3839, 201, 0));
    tbl.push_back(mk(0, 0, 1, 0,    0, 202,  1, 0, 0, 0, 1, 1, 0,    202, 0));
    tbl.push_back(mk(0, 0, 1, 0,    0, 203,  1, 0, 0, 0, 1, 1, 1,    203, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 1, 0, 0, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    // zero-length burst on requester 1, then a tie that requester 0 must win
    tbl.push_back(mk(0, 1, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 2, 0, 0, 0, 0, 0,    0,   0));
    // start address 3841 folds to 1 (holds 203 from the wrap burst)
    tbl.push_back(mk(1, 1, 0, 3841, 1, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    1, 0, 0, 0, 1, 0, 1,    0,   0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 1, 1, 0, 0, 0, 0,    0,   203));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 1, 0, 0, 0,    0,   0));

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outs",
        64'({o_gnt1, o_gnt0, o_done1, o_done0, o_rvalid1, o_rvalid0, o_idle, ce0, we0, addr0, d0,
             o_rdata0, o_rdata1}),
        64'({6'b0, 1'b1, 2'b0, 12'h0, 16'h0, 16'h0, 16'h0}));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      i_req0 = tbl[i].r0;  i_req1 = tbl[i].r1;
      i_we0  = tbl[i].wr;  i_we1  = tbl[i].wr;
      i_addr0 = tbl[i].a;  i_addr1 = tbl[i].a;
      i_len0  = tbl[i].l;  i_len1  = tbl[i].l;
      i_wdata0 = tbl[i].wd; i_wdata1 = tbl[i].wd;
      #2;
      rsel = tbl[i].rv[0] ? o_rdata0 : (tbl[i].rv[1] ? o_rdata1 : '0);
      act  = {o_gnt1, o_gnt0, o_done1, o_done0, o_rvalid1, o_rvalid0, o_idle, ce0, we0,
              addr0, d0, rsel};
      expv = {tbl[i].g, tbl[i].dn, tbl[i].rv, tbl[i].idle, tbl[i].ce, tbl[i].we,
              tbl[i].ad, tbl[i].d, tbl[i].rd};
      chk($sformatf("vec%0d", i), 64'(act), 64'(expv));
      chk($sformatf("own%0d", i),
          64'({o_gnt0 && o_gnt1, ce0 != (o_gnt0 || o_gnt1)}), 64'(0));
    end

    // Reset during the third beat of an 8-beat read on requester 0.
    @(negedge clk);
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = '0; i_len0 = 12'd8;
    @(negedge clk);
    i_req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("abort_pre_gnt_rv", 64'({o_gnt0, o_rvalid0, ce0}), 64'(3'b111));
    #1 reset_n = 1'b0;
    #1;
    chk("abort_ce0", 64'(ce0), 64'(0));
    chk("abort_gnt0", 64'(o_gnt0), 64'(0));
    chk("abort_rvalid0", 64'(o_rvalid0), 64'(0));
    chk("abort_idle", 64'(o_idle), 64'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("abort_nodone%0d", k), 64'({o_done0, o_done1, o_idle}), 64'(3'b001));
    end
    @(negedge clk);
    reset_n = 1'b1;
    i_req0 = 1'b1; i_we0 = 1'b1; i_addr0 = 12'd5; i_len0 = 12'd1; i_wdata0 = 16'd55;
    #2;
    chk("post_reset_idle", 64'({o_idle, o_gnt0, ce0}), 64'(3'b100));
    @(negedge clk);
    i_req0 = 1'b0;
    #2;
    chk("post_reset_beat", 64'({o_gnt0, ce0, we0, addr0, d0}), 64'({3'b111, 12'd5, 16'd55}));
    @(negedge clk);
    #2;
    chk("post_reset_done", 64'({o_done0, o_done1, ce0}), 64'(3'b100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
